// File: rtl/lsu_sequencer_pkg.sv
// Shared LSU types, funct3 size codes and size/alignment helpers.
// Imported by lsu_sequencer and lsu_align.
package common;

  typedef enum logic [1:0] {IDLE, REQ0, REQ1, DONE} lsu_state_t;

  localparam logic [2:0] LSU_B  = 3'b000;
  localparam logic [2:0] LSU_H  = 3'b001;
  localparam logic [2:0] LSU_W  = 3'b010;
  localparam logic [2:0] LSU_BU = 3'b100;
  localparam logic [2:0] LSU_HU = 3'b101;

  function automatic logic size_legal(input logic [2:0] s);
    return (s == LSU_B) || (s == LSU_H) || (s == LSU_W) ||
           (s == LSU_BU) || (s == LSU_HU);
  endfunction

  function automatic logic [2:0] size_bytes(input logic [2:0] s);
    case (s[1:0])
      2'b00:   return 3'd1;
      2'b01:   return 3'd2;
      default: return 3'd4;
    endcase
  endfunction

  function automatic logic [3:0] size_mask(input logic [2:0] s);
    case (s[1:0])
      2'b00:   return 4'b0001;
      2'b01:   return 4'b0011;
      default: return 4'b1111;
    endcase
  endfunction

  function automatic logic misaligned(
    input logic [2:0] s,
    input logic [1:0] off
  );
    return (s[1:0] == 2'b10 && off != 2'b00) ||
           (s[1:0] == 2'b01 && off[0]);
  endfunction

  // Second beat only when the bytes spill past the word boundary.
  function automatic logic crosses(
    input logic [2:0] s,
    input logic [1:0] off
  );
    return ({1'b0, off} + size_bytes(s)) > 3'd4;
  endfunction

endpackage

// File: rtl/lsu_sequencer_align.sv
// Lane steering for store beats and load extract/extend.
// Purely combinational.
module lsu_align
  import common::*;
(
  input  logic [2:0]  size,
  input  logic [1:0]  off,
  input  logic        beat1,
  input  logic [31:0] st_data,
  input  logic [31:0] lo,
  input  logic [31:0] hi,
  output logic [3:0]  be,
  output logic [31:0] lane_data,
  output logic [31:0] ld_data
);

  logic [3:0]  mask;
  logic [2:0]  rem;
  logic [31:0] win;

  always_comb begin
    mask = size_mask(size);
    rem  = 3'd4 - {1'b0, off};
    win  = 32'({hi, lo} >> {off, 3'b000});
    if (beat1) begin
      be        = mask >> rem;
      lane_data = st_data >> {rem, 3'b000};
    end else begin
      be        = mask << off;
      lane_data = st_data << {off, 3'b000};
    end
    case (size)
      LSU_B:   ld_data = {{24{win[7]}}, win[7:0]};
      LSU_H:   ld_data = {{16{win[15]}}, win[15:0]};
      LSU_W:   ld_data = win;
      LSU_BU:  ld_data = {24'b0, win[7:0]};
      LSU_HU:  ld_data = {16'b0, win[15:0]};
      default: ld_data = '0;
    endcase
  end

endmodule

// File: rtl/lsu_sequencer.sv
// Load/store sequencer: one or two bus beats per op, stalls the pipe.
// LSU_MISALIGNED_EN: execute misaligned ops (split) instead of rejecting.
module lsu_sequencer
  import common::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        ex_valid,
  input  logic        ctrl_mem_write,
  input  logic        ctrl_mem2reg,
  input  logic [2:0]  ctrl_word_size,
  input  logic [31:0] ex_addr,
  input  logic [31:0] ex_wdata,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_be,
  output logic [31:0] mem_wdata,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata,
  output logic        lsu_stall,
  output logic        wb_load_valid,
  output logic [31:0] wb_load_data,
  output logic        lsu_misaligned
);

  lsu_state_t  state, state_nx;
  logic [1:0]  off_q;
  logic [2:0]  size_q;
  logic [31:0] wdata_q, rbuf0, rbuf1;
  logic        we_q, split_q, mis_q;
  logic        op, idle, legal, reject, mis_nx, fin;
  logic [2:0]  a_size;
  logic [1:0]  a_off;
  logic [31:0] a_data, a_lo, a_hi, a_lane, a_load;
  logic [3:0]  a_be;

  assign op    = ex_valid & (ctrl_mem_write | ctrl_mem2reg);
  assign idle  = state == IDLE;
  assign legal = size_legal(ctrl_word_size);

`ifdef LSU_MISALIGNED_EN
  assign reject = !legal;
  assign mis_nx = 1'b0;
`else
  logic mis;
  assign mis    = misaligned(ctrl_word_size, ex_addr[1:0]);
  assign reject = !legal || mis;
  assign mis_nx = legal && mis;
`endif

  assign lsu_misaligned = mis_q;

  // In IDLE the aligner sees the incoming op; afterwards the captured one.
  assign a_size = idle ? ctrl_word_size : size_q;
  assign a_off  = idle ? ex_addr[1:0] : off_q;
  assign a_data = idle ? ex_wdata : wdata_q;
  assign a_lo   = (state == REQ0) ? mem_rdata : rbuf0;
  assign a_hi   = (state == REQ1) ? mem_rdata : rbuf1;

  lsu_align u_align (
    .size      (a_size),
    .off       (a_off),
    .beat1     (state == REQ0),
    .st_data   (a_data),
    .lo        (a_lo),
    .hi        (a_hi),
    .be        (a_be),
    .lane_data (a_lane),
    .ld_data   (a_load)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    if (op) state_nx = reject ? DONE : REQ0;
      REQ0:    if (mem_ack) state_nx = split_q ? REQ1 : DONE;
      REQ1:    if (mem_ack) state_nx = DONE;
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    lsu_stall = (idle && op) || state == REQ0 || state == REQ1;
    fin       = !idle && state_nx == DONE;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      off_q         <= '0;
      size_q        <= '0;
      wdata_q       <= '0;
      we_q          <= 1'b0;
      split_q       <= 1'b0;
      mis_q         <= 1'b0;
      rbuf0         <= '0;
      rbuf1         <= '0;
      mem_req       <= 1'b0;
      mem_we        <= 1'b0;
      mem_addr      <= '0;
      mem_be        <= '0;
      mem_wdata     <= '0;
      wb_load_valid <= 1'b0;
      wb_load_data  <= '0;
    end else begin
      wb_load_valid <= 1'b0;
      mis_q         <= 1'b0;
      if (idle && op) begin
        off_q   <= ex_addr[1:0];
        size_q  <= ctrl_word_size;
        wdata_q <= ex_wdata;
        we_q    <= ctrl_mem_write;
        split_q <= crosses(ctrl_word_size, ex_addr[1:0]);
        if (reject) begin
          wb_load_data <= '0;
          mis_q        <= mis_nx;
        end else begin
          mem_req   <= 1'b1;
          mem_we    <= ctrl_mem_write;
          mem_addr  <= {ex_addr[31:2], 2'b00};
          mem_be    <= a_be;
          mem_wdata <= a_lane;
        end
      end
      if (mem_ack && state == REQ0) rbuf0 <= mem_rdata;
      if (mem_ack && state == REQ1) rbuf1 <= mem_rdata;
      if (mem_ack && state == REQ0 && split_q) begin
        mem_addr  <= mem_addr + 32'd4;
        mem_be    <= a_be;
        mem_wdata <= a_lane;
      end
      if (fin) begin
        mem_req <= 1'b0;
        mem_we  <= 1'b0;
        if (!we_q) begin
          wb_load_valid <= 1'b1;
          wb_load_data  <= a_load;
        end
      end
    end
  end

endmodule

// File: tb/tb_lsu_sequencer.sv
// Directed bench for lsu_sequencer; expectations follow LSU_MISALIGNED_EN.
module tb_lsu_sequencer;
  import common::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        ex_valid, ctrl_mem_write, ctrl_mem2reg;
  logic [2:0]  ctrl_word_size;
  logic [31:0] ex_addr, ex_wdata;
  logic        mem_req, mem_we;
  logic [31:0] mem_addr, mem_wdata;
  logic [3:0]  mem_be;
  logic        mem_ack;
  logic [31:0] mem_rdata;
  logic        lsu_stall, wb_load_valid, lsu_misaligned;
  logic [31:0] wb_load_data;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  lsu_sequencer dut (
    .clk            (clk),
    .rst            (rst),
    .ex_valid       (ex_valid),
    .ctrl_mem_write (ctrl_mem_write),
    .ctrl_mem2reg   (ctrl_mem2reg),
    .ctrl_word_size (ctrl_word_size),
    .ex_addr        (ex_addr),
    .ex_wdata       (ex_wdata),
    .mem_req        (mem_req),
    .mem_we         (mem_we),
    .mem_addr       (mem_addr),
    .mem_be         (mem_be),
    .mem_wdata      (mem_wdata),
    .mem_ack        (mem_ack),
    .mem_rdata      (mem_rdata),
    .lsu_stall      (lsu_stall),
    .wb_load_valid  (wb_load_valid),
    .wb_load_data   (wb_load_data),
    .lsu_misaligned (lsu_misaligned)
  );

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic nxt();
    @(negedge clk);
  endtask

  task automatic present(input logic we, input logic ld,
                         input logic [2:0] sz, input logic [31:0] a,
                         input logic [31:0] d);
    ex_valid       = 1'b1;
    ctrl_mem_write = we;
    ctrl_mem2reg   = ld;
    ctrl_word_size = sz;
    ex_addr        = a;
    ex_wdata       = d;
  endtask

  task automatic idle_ex();
    ex_valid       = 1'b0;
    ctrl_mem_write = 1'b0;
    ctrl_mem2reg   = 1'b0;
  endtask

  // Single-beat load with zero-wait ack.
  task automatic load1(input string tag, input logic [2:0] sz,
                       input logic [31:0] a, input logic [31:0] rd,
                       input logic [31:0] ea, input logic [3:0] ebe,
                       input logic [31:0] ed);
    present(1'b0, 1'b1, sz, a, 32'h5555_5555);
    #1 chk({tag, " stall_T"}, lsu_stall, 1);
    nxt();
    chk({tag, " req"}, mem_req, 1);
    chk({tag, " we"}, mem_we, 0);
    chk({tag, " addr"}, mem_addr, ea);
    chk({tag, " be"}, mem_be, ebe);
    chk({tag, " stall_T1"}, lsu_stall, 1);
    mem_ack = 1'b1;
    mem_rdata = rd;
    nxt();
    mem_ack = 1'b0;
    mem_rdata = '0;
    chk({tag, " valid"}, wb_load_valid, 1);
    chk({tag, " data"}, wb_load_data, ed);
    chk({tag, " stall_done"}, lsu_stall, 0);
    chk({tag, " req_off"}, mem_req, 0);
    idle_ex();
    nxt();
    chk({tag, " valid_pulse"}, wb_load_valid, 0);
    chk({tag, " data_hold"}, wb_load_data, ed);
  endtask

  // Single-beat store with zero-wait ack.
  task automatic store1(input string tag, input logic [2:0] sz,
                        input logic [31:0] a, input logic [31:0] d,
                        input logic [31:0] ea, input logic [3:0] ebe,
                        input logic [31:0] ewd);
    present(1'b1, 1'b0, sz, a, d);
    nxt();
    chk({tag, " req"}, mem_req, 1);
    chk({tag, " we"}, mem_we, 1);
    chk({tag, " addr"}, mem_addr, ea);
    chk({tag, " be"}, mem_be, ebe);
    chk({tag, " wdata"}, mem_wdata, ewd);
    mem_ack = 1'b1;
    nxt();
    mem_ack = 1'b0;
    chk({tag, " no_valid"}, wb_load_valid, 0);
    chk({tag, " req_off"}, mem_req, 0);
    idle_ex();
    nxt();
  endtask

  initial begin
    rst = 1'b1;
    idle_ex();
    ctrl_word_size = '0;
    ex_addr   = '0;
    ex_wdata  = '0;
    mem_ack   = 1'b0;
    mem_rdata = '0;
    nxt();
    nxt();
    chk("rst req", mem_req, 0);
    chk("rst we", mem_we, 0);
    chk("rst addr", mem_addr, 0);
    chk("rst be", mem_be, 0);
    chk("rst wdata", mem_wdata, 0);
    chk("rst valid", wb_load_valid, 0);
    chk("rst ldata", wb_load_data, 0);
    chk("rst mis", lsu_misaligned, 0);
    chk("rst stall", lsu_stall, 0);
    rst = 1'b0;
    nxt();

    load1("lw", LSU_W, 32'h100, 32'hDEAD_BEEF, 32'h100, 4'b1111,
          32'hDEAD_BEEF);
    load1("lb", LSU_B, 32'h103, 32'h80FF_FFFF, 32'h100, 4'b1000,
          32'hFFFF_FF80);
    load1("lbu", LSU_BU, 32'h103, 32'h80FF_FFFF, 32'h100, 4'b1000,
          32'h0000_0080);
    load1("lh", LSU_H, 32'h102, 32'h8001_BEEF, 32'h100, 4'b1100,
          32'hFFFF_8001);
    load1("lhu", LSU_HU, 32'h102, 32'h8001_BEEF, 32'h100, 4'b1100,
          32'h0000_8001);
    store1("sh", LSU_H, 32'h202, 32'h0000_1234, 32'h200, 4'b1100,
           32'h1234_0000);
    store1("sb", LSU_B, 32'h101, 32'h0000_005A, 32'h100, 4'b0010,
           32'h0000_5A00);

    // Stray ack while idle must not start anything.
    mem_ack = 1'b1;
    nxt();
    mem_ack = 1'b0;
    chk("ack_idle req", mem_req, 0);
    chk("ack_idle valid", wb_load_valid, 0);

    // Illegal size: straight to DONE, zero data, no valid.
    present(1'b0, 1'b1, 3'b011, 32'h104, 32'h0);
    #1 chk("ill stall", lsu_stall, 1);
    nxt();
    chk("ill req", mem_req, 0);
    chk("ill valid", wb_load_valid, 0);
    chk("ill data", wb_load_data, 0);
    chk("ill mis", lsu_misaligned, 0);
    chk("ill stall_done", lsu_stall, 0);
    idle_ex();
    nxt();

    // Misaligned SW crossing a word.
    present(1'b1, 1'b0, LSU_W, 32'h301, 32'hAABB_CCDD);
    #1 chk("sw_mis stall", lsu_stall, 1);
    nxt();
`ifdef LSU_MISALIGNED_EN
    chk("sw_mis b0 req", mem_req, 1);
    chk("sw_mis b0 we", mem_we, 1);
    chk("sw_mis b0 addr", mem_addr, 32'h300);
    chk("sw_mis b0 be", mem_be, 4'b1110);
    chk("sw_mis b0 wdata", mem_wdata, 32'hBBCC_DD00);
    mem_ack = 1'b1;
    nxt();
    mem_ack = 1'b0;
    chk("sw_mis b1 req", mem_req, 1);
    chk("sw_mis b1 addr", mem_addr, 32'h304);
    chk("sw_mis b1 be", mem_be, 4'b0001);
    chk("sw_mis b1 wdata", mem_wdata, 32'h0000_00AA);
    mem_ack = 1'b1;
    nxt();
    mem_ack = 1'b0;
    chk("sw_mis done req", mem_req, 0);
    chk("sw_mis done mis", lsu_misaligned, 0);
    chk("sw_mis done valid", wb_load_valid, 0);
`else
    chk("sw_mis req", mem_req, 0);
    chk("sw_mis pulse", lsu_misaligned, 1);
    chk("sw_mis valid", wb_load_valid, 0);
    chk("sw_mis stall_done", lsu_stall, 0);
`endif
    idle_ex();
    nxt();
    chk("sw_mis pulse_end", lsu_misaligned, 0);

    // Misaligned LH at 0x3FF with three wait cycles per beat.
    present(1'b0, 1'b1, LSU_H, 32'h3FF, 32'h0);
    nxt();
`ifdef LSU_MISALIGNED_EN
    mem_rdata = 32'hFFFF_FFFF;
    for (int i = 0; i < 3; i++) begin
      chk("lh_x b0 req", mem_req, 1);
      chk("lh_x b0 addr", mem_addr, 32'h3FC);
      chk("lh_x b0 be", mem_be, 4'b1000);
      chk("lh_x b0 stall", lsu_stall, 1);
      nxt();
    end
    mem_ack = 1'b1;
    mem_rdata = 32'h11AA_BBCC;
    nxt();
    mem_ack = 1'b0;
    mem_rdata = 32'hFFFF_FFFF;
    for (int i = 0; i < 3; i++) begin
      chk("lh_x b1 req", mem_req, 1);
      chk("lh_x b1 addr", mem_addr, 32'h400);
      chk("lh_x b1 be", mem_be, 4'b0001);
      nxt();
    end
    mem_ack = 1'b1;
    mem_rdata = 32'hDDEE_FF22;
    nxt();
    mem_ack = 1'b0;
    mem_rdata = '0;
    chk("lh_x valid", wb_load_valid, 1);
    chk("lh_x data", wb_load_data, 32'h0000_2211);
    chk("lh_x stall_done", lsu_stall, 0);
`else
    chk("lh_x req", mem_req, 0);
    chk("lh_x pulse", lsu_misaligned, 1);
    chk("lh_x valid", wb_load_valid, 0);
`endif
    idle_ex();
    nxt();

    // Odd-halfword inside a word: one beat when enabled.
`ifdef LSU_MISALIGNED_EN
    load1("lh_odd", LSU_H, 32'h101, 32'h00CA_FE00, 32'h100, 4'b0110,
          32'hFFFF_CAFE);
`else
    present(1'b0, 1'b1, LSU_H, 32'h101, 32'h0);
    nxt();
    chk("lh_odd pulse", lsu_misaligned, 1);
    chk("lh_odd req", mem_req, 0);
    idle_ex();
    nxt();
`endif

    // Reset during REQ0.
    present(1'b0, 1'b1, LSU_W, 32'h500, 32'h0);
    nxt();
    chk("rst_mid req_before", mem_req, 1);
    #1 rst = 1'b1;
    #1 chk("rst_mid req_drop", mem_req, 0);
    idle_ex();
    nxt();
    rst = 1'b0;
    nxt();
    chk("rst_mid valid", wb_load_valid, 0);
    chk("rst_mid stall", lsu_stall, 0);
    load1("post_rst", LSU_W, 32'h600, 32'h0BAD_F00D, 32'h600, 4'b1111,
          32'h0BAD_F00D);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
